hash_block_adapter: RTL and testbench
=====================================

# hash_block_adapter

Parametrised, word-serial front end for the CEP hash cores. It buffers a stream of input words into one padded message block. It optionally byte-reverses each lane and issues the block to a hash core through a valid/ready handshake. It then captures the core's digest, optionally byte-reversed, and holds it until the host acknowledges it. It sits between the bus-side register logic and a block-oriented core such as the MD5 core, and is written so other hash cores can reuse it.

## Interface
Parameters:
- WORD_W, 64: width of each input word; BLOCK_W must be a multiple of WORD_W.
- BLOCK_W, 512: message block width; NWORDS = BLOCK_W/WORD_W.
- LANE_W, 64: byte-reversal granularity; multiple of 8, divides BLOCK_W.
- DIGEST_W, 128: digest width.
- DIGEST_SWAP, 0: 1 = byte-reverse each LANE_W lane of the digest (DIGEST_W must then be a multiple of LANE_W).

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- init, in, 1: synchronous clear; starts a new message.
- swap_en, in, 1: 1 = byte-reverse each LANE_W lane of the block.
- in_data, in, WORD_W: input word.
- in_valid, in, 1: in_data valid.
- in_ready, out, 1: word accepted when in_valid && in_ready.
- core_init, out, 1: one-cycle init pulse to core.
- core_msg, out, BLOCK_W: block to core.
- core_msg_valid, out, 1: block valid; single cycle.
- core_ready, in, 1: core can accept a block.
- core_digest, in, DIGEST_W: core output.
- core_digest_valid, in, 1: core output valid.
- digest, out, DIGEST_W: captured digest.
- digest_valid, out, 1: digest holds a fresh result.
- digest_ack, in, 1: host consumed the digest.

## Operation
- The FSM has four states: FILL, ISSUE, WAIT, DONE. Reset state is FILL.
- FILL:
  - in_ready=1.
  - Each accepted word shifts in at the LSB end, so the first word lands in the MSBs (big-endian stream order).
  - swap_en is latched on the first word of each block.
  - When word NWORDS-1 is accepted, the FSM moves to ISSUE.
- ISSUE:
  - in_ready=0.
  - core_msg_valid=core_ready, and core_msg is presented with the swap applied.
  - When core_ready=1, the FSM moves to WAIT.
- WAIT:
  - When core_digest_valid=1, digest is loaded (swapped if DIGEST_SWAP), digest_valid is set, and the FSM moves to DONE.
- DONE:
  - in_ready=0.
  - When digest_ack=1, digest_valid is cleared, the word counter is cleared, and the FSM moves to FILL.
  - digest keeps its value until the next capture.
- Swap: each LANE_W lane has its bytes reversed (byte 0 ↔ byte LANE_W/8-1). It is purely combinational on the stored block.
- core_digest_valid outside WAIT is ignored.
- init (any state):
  - Next cycle: state FILL, counter 0, digest_valid 0, core_init=1 for one cycle.
  - The block buffer is not cleared.
  - init has priority over every handshake in the same cycle.
- rst: all registers cleared asynchronously.

## Timing
- Reset values: in_ready=1, core_init=0, core_msg_valid=0, core_msg=0, digest=0, digest_valid=0.
- Throughput: one word per cycle in FILL, with no bubbles.
- Last word accepted at cycle t: core_msg_valid is high at t+1 if core_ready is high.
- core_digest_valid at cycle t: digest and digest_valid are visible at t+1.
- digest_ack at cycle t: in_ready=1 at t+1.
- in_valid while in_ready=0 is held off; the word is not lost.
- rst asserted mid-block discards the partial block.

## Structure
- Package hash_adapter_pkg holds:
  - the FSM state enum;
  - the function byte_swap_lanes(data, LANE_W).
- Sub-module lane_byte_swap (parametrised width and lane width, combinational) is instantiated twice: once for the block, once for the digest when DIGEST_SWAP=1.

## Test plan
- Defaults, swap_en=1, words 0x0011223344556677 then 0x1…7 filler:
  - core_msg[511:448]=0x7766554433221100.
  - core_msg_valid pulses once.
- swap_en=0, same words:
  - core_msg[511:448]=0x0011223344556677, unchanged order.
- core_ready held low 5 cycles in ISSUE:
  - core_msg_valid stays low.
  - in_ready=0 throughout.
  - The block is issued on the first cycle core_ready=1.
- DIGEST_SWAP=1, core_digest=0x00112233445566778899AABBCCDDEEFF:
  - digest=0x7766554433221100FFEEDDCCBBAA9988.
  - digest holds until digest_ack.
- init asserted after 3 words:
  - core_init pulses once.
  - The next 8 words form a complete block, and the 3 stale words are absent from the block.
- rst asserted during WAIT:
  - All outputs return to reset values.
  - A core_digest_valid arriving after rst releases is ignored.

Source files
------------

// File: rtl/hash_adapter_pkg.sv
// Shared types and helpers for the hash block adapter.
package hash_adapter_pkg;

  // Adapter control states.
  typedef enum logic [1:0] {
    StFill,
    StIssue,
    StWait,
    StDone
  } state_e;

  // Widest vector byte_swap_lanes can handle; callers zero-pad up to this width.
  localparam int unsigned MaxSwapW = 1024;

  // Reverse the bytes inside every lane_w-bit lane (byte 0 <-> byte lane_w/8-1).
  function automatic logic [MaxSwapW-1:0] byte_swap_lanes(input logic [MaxSwapW-1:0] data,
                                                          input int unsigned lane_w);
    int unsigned lane_b;
    int unsigned lane;
    int unsigned idx;
    int unsigned src;
    logic [MaxSwapW-1:0] res;
    lane_b = lane_w / 8;
    res    = data;
    for (int unsigned b = 0; b < MaxSwapW / 8; b++) begin
      lane = b / lane_b;
      idx  = b % lane_b;
      src  = lane * lane_b + (lane_b - 1 - idx);
      // A partial lane at the very top of the padded vector is left untouched.
      if (src < MaxSwapW / 8) begin
        res[b*8 +: 8] = data[src*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hash_block_adapter_if.sv
// Handshake bundle between the host stream, the adapter and the hash core.
interface hash_block_adapter_if #(
  parameter int unsigned WORD_W   = 64,
  parameter int unsigned BLOCK_W  = 512,
  parameter int unsigned DIGEST_W = 128
);
  logic                init;
  logic                swap_en;
  logic [WORD_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic                core_init;
  logic [BLOCK_W-1:0]  core_msg;
  logic                core_msg_valid;
  logic                core_ready;
  logic [DIGEST_W-1:0] core_digest;
  logic                core_digest_valid;
  logic [DIGEST_W-1:0] digest;
  logic                digest_valid;
  logic                digest_ack;

  // Environment side: host stream plus the hash core model.
  modport master (
    output init, swap_en, in_data, in_valid, core_ready, core_digest, core_digest_valid,
           digest_ack,
    input  in_ready, core_init, core_msg, core_msg_valid, digest, digest_valid
  );

  // Adapter side.
  modport slave (
    input  init, swap_en, in_data, in_valid, core_ready, core_digest, core_digest_valid,
           digest_ack,
    output in_ready, core_init, core_msg, core_msg_valid, digest, digest_valid
  );
endinterface

// File: rtl/lane_byte_swap.sv
// Combinational per-lane byte reversal of a Width-bit vector.
module lane_byte_swap
  import hash_adapter_pkg::*;
#(
  parameter int unsigned Width = 512,
  parameter int unsigned LaneW = 64
) (
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);
  logic [MaxSwapW-1:0] padded;
  logic [MaxSwapW-1:0] swapped;
  logic                unused_swapped;

  // Zero-extend into the helper's fixed working width.
  always_comb begin
    padded              = '0;
    padded[Width-1:0]   = data_i;
  end

  assign swapped        = byte_swap_lanes(padded, LaneW);
  assign data_o         = swapped[Width-1:0];
  // Padding lanes above Width carry nothing useful.
  assign unused_swapped = ^swapped;
endmodule

// File: rtl/hash_block_adapter.sv
// Word-serial block builder and digest holder in front of a block hash core.
module hash_block_adapter
  import hash_adapter_pkg::*;
#(
  parameter int unsigned WORD_W      = 64,
  parameter int unsigned BLOCK_W     = 512,
  parameter int unsigned LANE_W      = 64,
  parameter int unsigned DIGEST_W    = 128,
  parameter bit          DIGEST_SWAP = 1'b0
) (
  input logic                clk,
  input logic                rst,
  hash_block_adapter_if.slave bus
);
  localparam int unsigned    NWORDS  = BLOCK_W / WORD_W;
  localparam int unsigned    CntW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NWORDS - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BLOCK_W-1:0]  block_q, block_d;
  logic                swap_q, swap_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic                digest_valid_q, digest_valid_d;
  logic                core_init_q, core_init_d;
  logic [BLOCK_W-1:0]  block_swapped;
  logic [DIGEST_W-1:0] digest_in;

  lane_byte_swap #(
    .Width (BLOCK_W),
    .LaneW (LANE_W)
  ) u_block_swap (
    .data_i (block_q),
    .data_o (block_swapped)
  );

  if (DIGEST_SWAP) begin : g_digest_swap
    lane_byte_swap #(
      .Width (DIGEST_W),
      .LaneW (LANE_W)
    ) u_digest_swap (
      .data_i (bus.core_digest),
      .data_o (digest_in)
    );
  end else begin : g_digest_raw
    assign digest_in = bus.core_digest;
  end

  assign bus.core_msg     = swap_q ? block_swapped : block_q;
  assign bus.core_init    = core_init_q;
  assign bus.digest       = digest_q;
  assign bus.digest_valid = digest_valid_q;

  // Next-state, datapath updates and handshake outputs; init overrides everything.
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    block_d            = block_q;
    swap_d             = swap_q;
    digest_d           = digest_q;
    digest_valid_d     = digest_valid_q;
    core_init_d        = 1'b0;
    bus.in_ready       = 1'b0;
    bus.core_msg_valid = 1'b0;
    if (bus.init) begin
      // Block buffer is deliberately kept; the next NWORDS words overwrite it.
      state_d        = StFill;
      cnt_d          = '0;
      digest_valid_d = 1'b0;
      core_init_d    = 1'b1;
    end else begin
      unique case (state_q)
        StFill: begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            block_d = (block_q << WORD_W) | BLOCK_W'(bus.in_data);
            if (cnt_q == '0) begin
              swap_d = bus.swap_en;
            end
            if (cnt_q == LastCnt) begin
              cnt_d   = '0;
              state_d = StIssue;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StIssue: begin
          bus.core_msg_valid = bus.core_ready;
          if (bus.core_ready) begin
            state_d = StWait;
          end
        end
        StWait: begin
          if (bus.core_digest_valid) begin
            digest_d       = digest_in;
            digest_valid_d = 1'b1;
            state_d        = StDone;
          end
        end
        StDone: begin
          if (bus.digest_ack) begin
            digest_valid_d = 1'b0;
            cnt_d          = '0;
            state_d        = StFill;
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StFill;
      cnt_q          <= '0;
      block_q        <= '0;
      swap_q         <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      core_init_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      block_q        <= block_d;
      swap_q         <= swap_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      core_init_q    <= core_init_d;
    end
  end
endmodule

// File: tb/tb_hash_block_adapter.sv
// Scoreboard bench for hash_block_adapter with digest lane swapping enabled.
module tb_hash_block_adapter;
  localparam int unsigned WordW   = 64;
  localparam int unsigned BlockW  = 512;
  localparam int unsigned LaneW   = 64;
  localparam int unsigned DigestW = 128;

  logic clk;
  logic rst;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [BlockW-1:0] msg_q[$];

  hash_block_adapter_if #(
    .WORD_W   (WordW),
    .BLOCK_W  (BlockW),
    .DIGEST_W (DigestW)
  ) bus ();

  hash_block_adapter #(
    .WORD_W      (WordW),
    .BLOCK_W     (BlockW),
    .LANE_W      (LaneW),
    .DIGEST_W    (DigestW),
    .DIGEST_SWAP (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] swap_blk(input logic [511:0] d);
    logic [63:0]  l;
    logic [63:0]  r;
    logic [511:0] res;
    for (int i = 0; i < 8; i++) begin
      l = d[i*64 +: 64];
      r = {<<8{l}};
      res[i*64 +: 64] = r;
    end
    return res;
  endfunction

  function automatic logic [127:0] swap_dig(input logic [127:0] d);
    logic [63:0]  l;
    logic [63:0]  r;
    logic [127:0] res;
    for (int i = 0; i < 2; i++) begin
      l = d[i*64 +: 64];
      r = {<<8{l}};
      res[i*64 +: 64] = r;
    end
    return res;
  endfunction

  function automatic logic [511:0] build_blk(input logic [63:0] w [8]);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b = {b[447:0], w[i]};
    return b;
  endfunction

  // Compare every issued block against the oldest expected block.
  always @(negedge clk) begin
    if (!rst && bus.core_msg_valid) begin
      check_eq("sb_pending", msg_q.size(), 1);
      if (msg_q.size() != 0) check_eq("core_msg", bus.core_msg, msg_q.pop_front());
    end
  end

  task automatic check_reset_outputs();
    check_eq("rst_in_ready", bus.in_ready, 1'b1);
    check_eq("rst_core_init", bus.core_init, 1'b0);
    check_eq("rst_core_msg_valid", bus.core_msg_valid, 1'b0);
    check_eq("rst_core_msg", bus.core_msg, '0);
    check_eq("rst_digest", bus.digest, '0);
    check_eq("rst_digest_valid", bus.digest_valid, 1'b0);
  endtask

  task automatic feed_word(input logic [63:0] w);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    check_eq("fill_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] w [8], input bit swap, input int delay,
                            input logic [63:0] exp_top);
    logic [511:0] blk;
    blk = build_blk(w);
    msg_q.push_back(swap ? swap_blk(blk) : blk);
    bus.swap_en    = swap;
    bus.core_ready = (delay == 0);
    for (int i = 0; i < 8; i++) begin
      feed_word(w[i]);
      bus.swap_en = ~swap;  // only the first word's swap_en should count
    end
    for (int d = 0; d < delay; d++) begin
      check_eq("stall_msg_valid", bus.core_msg_valid, 1'b0);
      check_eq("stall_in_ready", bus.in_ready, 1'b0);
      tick();
    end
    bus.core_ready = 1'b1;
    #1;
    check_eq("issue_msg_valid", bus.core_msg_valid, 1'b1);
    check_eq("issue_in_ready", bus.in_ready, 1'b0);
    check_eq("issue_top_lane", bus.core_msg[511:448], exp_top);
    tick();
    check_eq("single_pulse", bus.core_msg_valid, 1'b0);
    bus.core_ready = 1'b0;
  endtask

  task automatic do_digest(input logic [127:0] dig, input logic [127:0] exp, input int hold,
                           input bit pend, input logic [63:0] pw);
    check_eq("wait_digest_valid", bus.digest_valid, 1'b0);
    bus.core_digest       = dig;
    bus.core_digest_valid = 1'b1;
    tick();
    bus.core_digest_valid = 1'b0;
    check_eq("capture_valid", bus.digest_valid, 1'b1);
    check_eq("capture_digest", bus.digest, exp);
    if (pend) begin
      bus.in_data  = pw;
      bus.in_valid = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      bus.core_digest       = ~dig;
      bus.core_digest_valid = 1'b1;
      tick();
      check_eq("hold_digest", bus.digest, exp);
      check_eq("hold_valid", bus.digest_valid, 1'b1);
      check_eq("done_in_ready", bus.in_ready, 1'b0);
    end
    bus.core_digest_valid = 1'b0;
    bus.digest_ack        = 1'b1;
    tick();
    bus.digest_ack = 1'b0;
    check_eq("ack_in_ready", bus.in_ready, 1'b1);
    check_eq("ack_valid", bus.digest_valid, 1'b0);
    check_eq("ack_digest_kept", bus.digest, exp);
  endtask

  initial begin
    logic [63:0]  wa [8];
    logic [63:0]  wc [8];
    logic [63:0]  wd [8];
    logic [511:0] tmp;
    logic [127:0] dig;

    rst                   = 1'b1;
    bus.init              = 1'b0;
    bus.swap_en           = 1'b0;
    bus.in_data           = '0;
    bus.in_valid          = 1'b0;
    bus.core_ready        = 1'b0;
    bus.core_digest       = '0;
    bus.core_digest_valid = 1'b0;
    bus.digest_ack        = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    tick();

    // Swapped block, spec digest; the next block's first word is held off in DONE.
    wa[0] = 64'h0011223344556677;
    for (int i = 1; i < 8; i++) wa[i] = 64'(i);
    send_block(wa, 1'b1, 0, 64'h7766554433221100);
    do_digest(128'h00112233445566778899AABBCCDDEEFF, 128'h7766554433221100FFEEDDCCBBAA9988,
              3, 1'b1, wa[0]);

    // Same words without swap.
    send_block(wa, 1'b0, 0, 64'h0011223344556677);
    dig = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    do_digest(dig, swap_dig(dig), 1, 1'b0, '0);

    // Core back-pressure for 5 cycles on a random block.
    for (int i = 0; i < 8; i++) wc[i] = {$urandom, $urandom};
    tmp = swap_blk(build_blk(wc));
    send_block(wc, 1'b1, 5, tmp[511:448]);
    dig = {$urandom, $urandom, $urandom, $urandom};
    do_digest(dig, swap_dig(dig), 0, 1'b0, '0);

    // init after 3 stale words; a word offered alongside init must be dropped.
    for (int i = 0; i < 3; i++) feed_word(64'hdead_0000_0000_0000 | 64'(i));
    bus.in_data  = 64'hbad0_bad0_bad0_bad0;
    bus.in_valid = 1'b1;
    bus.init     = 1'b1;
    tick();
    bus.init     = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("core_init_pulse", bus.core_init, 1'b1);
    tick();
    check_eq("core_init_clear", bus.core_init, 1'b0);
    for (int i = 0; i < 8; i++) wd[i] = 64'h1000_0000_0000_0000 + 64'(i * 3);
    send_block(wd, 1'b0, 0, wd[0]);
    dig = 128'hfedcba98765432100123456789abcdef;
    do_digest(dig, swap_dig(dig), 0, 1'b0, '0);

    // Reset while waiting for the digest; a late digest must be ignored.
    send_block(wc, 1'b0, 0, wc[0]);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    tick();
    rst = 1'b0;
    bus.core_digest       = 128'h11112222333344445555666677778888;
    bus.core_digest_valid = 1'b1;
    tick();
    bus.core_digest_valid = 1'b0;
    check_eq("post_rst_valid", bus.digest_valid, 1'b0);
    check_eq("post_rst_digest", bus.digest, '0);
    check_eq("post_rst_in_ready", bus.in_ready, 1'b1);

    // Recovery after reset.
    send_block(wa, 1'b1, 0, 64'h7766554433221100);
    dig = 128'h00112233445566778899AABBCCDDEEFF;
    do_digest(dig, 128'h7766554433221100FFEEDDCCBBAA9988, 0, 1'b0, '0);

    tick();
    check_eq("sb_drained", msg_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
